controle_cpu: RTL and testbench

Sequencing controller for the 16-bit ALU (`ula`). It accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it. It owns an 8×16 register file and drives the ALU operands and opcode, then writes the result back. It also runs the multi-cycle CLR sweep and presents DISP results on a display handshake. It sits between the instruction source (switch/ROM front end) and the display driver.

---
 rtl/controle_cpu.sv | 154 +++++++++++++++
 tb/tb_controle_cpu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controle_cpu : sequencing controller for the 16-bit ula (regfile, CLR, DISP)|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module controle_cpu #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_DISP  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DISP = 3'b111;

  logic [2:0]        state_q, state_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [2:0]        k_q;
  logic              flag_z_q, flag_n_q;
  logic [DATA_W-1:0] regs_q [8];

  logic [2:0]        op_w, rd_w, rs1_w, rs2_w;
  logic [DATA_W-1:0] imm7_w, imm10_w;

  assign op_w    = ir_q[15:13];
  assign rd_w    = ir_q[12:10];
  assign rs1_w   = ir_q[9:7];
  assign rs2_w   = ir_q[6:4];
  assign imm7_w  = {{(DATA_W-7){ir_q[6]}}, ir_q[6:0]};
  assign imm10_w = {{(DATA_W-10){ir_q[9]}}, ir_q[9:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = (instr[15:13] == OP_CLR) ? S_CLEAR : S_EXEC;
      S_EXEC:  state_d = (op_w == OP_DISP) ? S_DISP : S_WB;
      S_WB:    state_d = S_IDLE;
      S_DISP:  if (disp_ready) state_d = S_IDLE;
      S_CLEAR: if (k_q == 3'd7) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    disp_valid  = 1'b0;
    done        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 3'd0;
    case (state_q)
      S_IDLE: instr_ready = 1'b1;
      S_EXEC: begin
        alu_op = op_w;
        case (op_w)
          OP_LOAD:                 alu_b = imm10_w;
          OP_ADD, OP_SUB, OP_MUL: begin
            alu_a = regs_q[rs1_w];
            alu_b = regs_q[rs2_w];
          end
          OP_ADDI, OP_SUBI: begin
            alu_a = regs_q[rs1_w];
            alu_b = imm7_w;
          end
          OP_DISP:                 alu_a = regs_q[rs1_w];
          default:                 alu_a = '0;
        endcase
      end
      S_WB:    done = 1'b1;
      S_DISP: begin
        disp_valid = 1'b1;
        done       = disp_ready;
      end
      S_CLEAR: done = (k_q == 3'd7);
      default: instr_ready = 1'b0;
    endcase
  end

  // Datapath: instruction latch, result capture, register file and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q        <= '0;
      res_q       <= '0;
      disp_data_q <= '0;
      k_q         <= '0;
      flag_z_q    <= 1'b1;
      flag_n_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (instr_valid) ir_q <= instr;
        S_EXEC: begin
          res_q <= alu_res;
          if (op_w == OP_DISP) disp_data_q <= alu_res;
        end
        S_WB: begin
          regs_q[rd_w] <= res_q;
          flag_z_q     <= (res_q == '0);
          flag_n_q     <= res_q[DATA_W-1];
        end
        S_CLEAR: begin
          regs_q[k_q] <= '0;
          k_q         <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            flag_z_q <= 1'b1;
            flag_n_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_data = disp_data_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_controle_cpu.sv
`default_nettype none
// Directed self-checking bench for controle_cpu with a behavioural ula model.
module tb_controle_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_res, disp_data, dbg_data;
  logic [2:0]  alu_op, dbg_sel;
  logic        disp_valid, disp_ready, done, flag_z, flag_n;

  int checks = 0;
  int errors = 0;

  controle_cpu #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .done(done), .flag_z(flag_z), .flag_n(flag_n),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ula: LOAD/ADD/ADDI/DISP add, SUB/SUBI subtract, MUL low 16 bits
  always_comb begin
    alu_res = 16'h0000;
    case (alu_op)
      3'd0, 3'd1, 3'd2, 3'd7: alu_res = alu_a + alu_b;
      3'd3, 3'd4:             alu_res = alu_a - alu_b;
      3'd5:                   alu_res = 16'(alu_a * alu_b);
      default:                alu_res = 16'h0000;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one register-writing instruction; returns done seen in the WB cycle.
  task automatic run_instr(input logic [15:0] w, output logic done_wb);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    done_wb = done;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; disp_ready = 1'b0; instr = 16'h0; dbg_sel = 3'd0;
    tick(); tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_instr_ready got %b want 1", instr_ready); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got %b want 0", disp_valid); end
    checks++; if (disp_data !== 16'h0) begin errors++; $display("FAIL rst_disp_data got %h want 0000", disp_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL rst_flags got %b want 10", {flag_z, flag_n}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 35'h0) begin errors++; $display("FAIL rst_alu got %h want 0", {alu_a, alu_b, alu_op}); end
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r); #1;
      checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL rst_reg%0d got %h want 0000", r, dbg_data); end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    instr = {3'b000, 3'd3, 10'h3FF}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL load_exec_ready got %b want 0", instr_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== {16'h0000, 16'hFFFF, 3'd0}) begin errors++; $display("FAIL load_exec_alu got %h want %h", {alu_a, alu_b, alu_op}, {16'h0000, 16'hFFFF, 3'd0}); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_exec_done got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_wb_done got %b want 1", done); end
    checks++; if ({alu_a, alu_b, alu_op} !== 35'h0) begin errors++; $display("FAIL load_wb_alu got %h want 0", {alu_a, alu_b, alu_op}); end
    tick();
    dbg_sel = 3'd3; #1;
    checks++; if (dbg_data !== 16'hFFFF) begin errors++; $display("FAIL load_r3 got %h want ffff", dbg_data); end
    checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL load_flags got %b want 01", {flag_z, flag_n}); end
    checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL load_retire got done=%b ready=%b want 0 1", done, instr_ready); end
  endtask

  task automatic test_mul_subi();
    logic d;
    run_instr({3'b000, 3'd1, 10'd5}, d);
    run_instr({3'b000, 3'd2, 10'd7}, d);
    run_instr({3'b101, 3'd4, 3'd1, 3'd2, 4'd0}, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL mul_done got %b want 1", d); end
    dbg_sel = 3'd4; #1;
    checks++; if (dbg_data !== 16'd35) begin errors++; $display("FAIL mul_r4 got %h want 0023", dbg_data); end
    checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL mul_flags got %b want 00", {flag_z, flag_n}); end
    run_instr({3'b100, 3'd4, 3'd4, 7'h23}, d);
    dbg_sel = 3'd4; #1;
    checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL subi_r4 got %h want 0000", dbg_data); end
    checks++; if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL subi_flags got %b want 10", {flag_z, flag_n}); end
  endtask

  task automatic test_wrap();
    logic d;
    run_instr({3'b010, 3'd5, 3'd5, 7'h7F}, d);
    dbg_sel = 3'd5; #1;
    checks++; if (dbg_data !== 16'hFFFF) begin errors++; $display("FAIL addi_r5 got %h want ffff", dbg_data); end
    run_instr({3'b001, 3'd5, 3'd5, 3'd5, 4'd0}, d);
    dbg_sel = 3'd5; #1;
    checks++; if (dbg_data !== 16'hFFFE) begin errors++; $display("FAIL add_r5 got %h want fffe", dbg_data); end
    checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL add_flags got %b want 01", {flag_z, flag_n}); end
  endtask

  task automatic test_disp();
    instr = {3'b111, 3'd0, 3'd1, 7'd0}; instr_valid = 1'b1; disp_ready = 1'b0;
    tick();
    instr_valid = 1'b0;
    checks++; if ({alu_a, alu_op, disp_valid} !== {16'd5, 3'd7, 1'b0}) begin errors++; $display("FAIL disp_exec got a=%h op=%0d v=%b want 0005 7 0", alu_a, alu_op, disp_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({disp_valid, disp_data, instr_ready, done} !== {1'b1, 16'd5, 1'b0, 1'b0})
        begin errors++; $display("FAIL disp_hold%0d got v=%b d=%h rdy=%b done=%b want 1 0005 0 0", c, disp_valid, disp_data, instr_ready, done); end
    end
    disp_ready = 1'b1; #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL disp_done got %b want 1", done); end
    tick();
    disp_ready = 1'b0;
    checks++; if ({instr_ready, disp_valid, disp_data, done} !== {1'b1, 1'b0, 16'd5, 1'b0})
      begin errors++; $display("FAIL disp_after got rdy=%b v=%b d=%h done=%b want 1 0 0005 0", instr_ready, disp_valid, disp_data, done); end
    checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL disp_flags got %b want 01", {flag_z, flag_n}); end
  endtask

  task automatic test_clr();
    logic d;
    int   dones = 0;
    for (int r = 0; r < 8; r++) run_instr({3'b000, 3'(r), 10'(r + 1)}, d);
    dbg_sel = 3'd0; #1;
    checks++; if (dbg_data !== 16'd1) begin errors++; $display("FAIL clr_pre_r0 got %h want 0001", dbg_data); end
    instr = {3'b110, 13'd0}; instr_valid = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (done === 1'b1) dones++;
      checks++; if ({instr_ready, done} !== {1'b0, (c == 8)})
        begin errors++; $display("FAIL clr_cycle%0d got rdy=%b done=%b want 0 %b", c, instr_ready, done, (c == 8)); end
      tick();
    end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL clr_idle got %b want 1", instr_ready); end
    instr_valid = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL clr_done_count got %0d want 1", dones); end
    checks++; if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL clr_flags got %b want 10", {flag_z, flag_n}); end
    for (int r = 0; r < 8; r++) begin
      dbg_sel = 3'(r); #1;
      checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL clr_reg%0d got %h want 0000", r, dbg_data); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic d;
    run_instr({3'b000, 3'd1, 10'd3}, d);
    instr = {3'b001, 3'd6, 3'd1, 3'd1, 4'd0}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if ({alu_a, alu_b, alu_op} !== {16'd3, 16'd3, 3'd1}) begin errors++; $display("FAIL mid_exec_alu got %h want %h", {alu_a, alu_b, alu_op}, {16'd3, 16'd3, 3'd1}); end
    rst_n = 1'b0; #1;
    checks++; if ({instr_ready, done, disp_valid, disp_data} !== {1'b1, 1'b0, 1'b0, 16'h0})
      begin errors++; $display("FAIL mid_rst_ctl got rdy=%b done=%b v=%b d=%h want 1 0 0 0000", instr_ready, done, disp_valid, disp_data); end
    checks++; if ({alu_a, alu_b, alu_op, flag_z, flag_n} !== {35'h0, 2'b10})
      begin errors++; $display("FAIL mid_rst_alu_flags got %h want %h", {alu_a, alu_b, alu_op, flag_z, flag_n}, {35'h0, 2'b10}); end
    tick();
    dbg_sel = 3'd6; #1;
    checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL mid_r6 got %h want 0000", dbg_data); end
    dbg_sel = 3'd1; #1;
    checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL mid_r1 got %h want 0000", dbg_data); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic d;
    run_instr({3'b000, 3'd7, 10'h1FF}, d);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", instr_ready); end
    run_instr({3'b000, 3'd0, 10'h200}, d);
    dbg_sel = 3'd7; #1;
    checks++; if (dbg_data !== 16'h01FF) begin errors++; $display("FAIL b2b_r7 got %h want 01ff", dbg_data); end
    dbg_sel = 3'd0; #1;
    checks++; if (dbg_data !== 16'hFE00) begin errors++; $display("FAIL b2b_r0 got %h want fe00", dbg_data); end
    checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL b2b_flags got %b want 01", {flag_z, flag_n}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_mul_subi();
    test_wrap();
    test_disp();
    test_clr();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
